// File: rtl/iob_fifo_t2p_ctrl_pkg.sv
// ============================================================================
// Module      : iob_fifo_t2p_ctrl_pkg
// Description : Shared constants and types for the two-port RAM FIFO controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_fifo_t2p_ctrl_pkg;

    // Defaults kept equal to the companion two-port RAM configuration.
    localparam int c_ADDR_W_DEF = 4;
    localparam int c_DATA_W_DEF = 32;

    // Encoding is {push_accepted, pop_accepted}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

endpackage

`default_nettype wire

// File: rtl/iob_fifo_t2p_ptr.sv
// ============================================================================
// Module      : iob_fifo_t2p_ptr
// Description : Wrapping ADDR_W-bit pointer with enable and synchronous clear
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_fifo_t2p_ptr
    import iob_fifo_t2p_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] r_ptr;

    // Natural overflow of the ADDR_W-bit add gives the modulo-depth wrap.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_ptr <= '0;
        end else if (rst_i) begin
            r_ptr <= '0;
        end else if (en_i) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    assign ptr_o = r_ptr;

endmodule

`default_nettype wire

// File: rtl/iob_fifo_t2p_ctrl.sv
// ============================================================================
// Module      : iob_fifo_t2p_ctrl
// Description : FIFO controller driving an external true two-port RAM
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_fifo_t2p_ctrl
    import iob_fifo_t2p_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              w_en_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              w_full_o,
    output logic              w_overflow_o,
    input  logic              r_en_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_valid_o,
    output logic              r_empty_o,
    output logic              r_underflow_o,
    output logic [ADDR_W:0]   level_o,
    output logic              ext_mem_w_en_o,
    output logic [ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [DATA_W-1:0] ext_mem_w_data_o,
    output logic              ext_mem_r_en_o,
    output logic [ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [DATA_W-1:0] ext_mem_r_data_i
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

    logic              w_push;
    logic              w_pop;
    fifo_op_t          w_op;
    logic [ADDR_W:0]   w_level_nxt;
    logic [ADDR_W-1:0] w_wptr;
    logic [ADDR_W-1:0] w_rptr;

    logic [ADDR_W:0]   r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_valid;
    logic              r_overflow;
    logic              r_underflow;

    // Both requests are judged against the registered flags, so a pop on an
    // empty FIFO never falls through to a same-cycle push.
    assign w_push = w_en_i & ~r_full;
    assign w_pop  = r_en_i & ~r_empty;
    assign w_op   = fifo_op_t'({w_push, w_pop});

    always_comb begin
        w_level_nxt = r_level;
        case (w_op)
            OP_PUSH: w_level_nxt = r_level + c_ONE;
            OP_POP:  w_level_nxt = r_level - c_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    iob_fifo_t2p_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .rst_i    (rst_i),
        .en_i     (w_push),
        .ptr_o    (w_wptr)
    );

    iob_fifo_t2p_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .rst_i    (rst_i),
        .en_i     (w_pop),
        .ptr_o    (w_rptr)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (rst_i) begin
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_level     <= w_level_nxt;
            r_full      <= (w_level_nxt == c_DEPTH);
            r_empty     <= (w_level_nxt == '0);
            r_valid     <= w_pop;
            r_overflow  <= w_en_i & r_full;
            r_underflow <= r_en_i & r_empty;
        end
    end

    assign ext_mem_w_en_o   = w_push;
    assign ext_mem_w_addr_o = w_wptr;
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = w_pop;
    assign ext_mem_r_addr_o = w_rptr;

    assign r_data_o      = ext_mem_r_data_i;
    assign r_valid_o     = r_valid;
    assign r_empty_o     = r_empty;
    assign w_full_o      = r_full;
    assign w_overflow_o  = r_overflow;
    assign r_underflow_o = r_underflow;
    assign level_o       = r_level;

endmodule

`default_nettype wire

// File: tb/tb_iob_fifo_t2p_ctrl.sv
// ============================================================================
// Module      : tb_iob_fifo_t2p_ctrl
// Description : Directed self-checking bench with a behavioural two-port RAM
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_fifo_t2p_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              rst = 1'b0;
    logic              w_en = 1'b0;
    logic [DATA_W-1:0] w_data = '0;
    logic              r_en = 1'b0;
    logic              w_full, w_overflow, r_valid, r_empty, r_underflow;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W:0]   level;
    logic              m_w_en, m_r_en;
    logic [ADDR_W-1:0] m_w_addr, m_r_addr;
    logic [DATA_W-1:0] m_w_data;
    logic [DATA_W-1:0] m_r_data = '0;
    logic [DATA_W-1:0] mem [DEPTH];

    int passed = 0;
    int total  = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_word;

    always #5 clk = ~clk;

    iob_fifo_t2p_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
        .rst_i            (rst),
        .w_en_i           (w_en),
        .w_data_i         (w_data),
        .w_full_o         (w_full),
        .w_overflow_o     (w_overflow),
        .r_en_i           (r_en),
        .r_data_o         (r_data),
        .r_valid_o        (r_valid),
        .r_empty_o        (r_empty),
        .r_underflow_o    (r_underflow),
        .level_o          (level),
        .ext_mem_w_en_o   (m_w_en),
        .ext_mem_w_addr_o (m_w_addr),
        .ext_mem_w_data_o (m_w_data),
        .ext_mem_r_en_o   (m_r_en),
        .ext_mem_r_addr_o (m_r_addr),
        .ext_mem_r_data_i (m_r_data)
    );

    // Registered-read two-port RAM as the parent would attach it.
    always @(posedge clk) begin
        if (m_w_en) mem[m_w_addr] <= m_w_data;
        if (m_r_en) m_r_data <= mem[m_r_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        arst_n = 1'b1;
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_empty", 64'(r_empty), 64'd1);
        chk("rst_full", 64'(w_full), 64'd0);
        chk("rst_valid", 64'(r_valid), 64'd0);
        chk("rst_ovf", 64'(w_overflow), 64'd0);
        chk("rst_unf", 64'(r_underflow), 64'd0);
        chk("rst_mwen", 64'(m_w_en), 64'd0);
        chk("rst_mren", 64'(m_r_en), 64'd0);
        chk("rst_waddr", 64'(m_w_addr), 64'd0);
        chk("rst_raddr", 64'(m_r_addr), 64'd0);

        // ---------------- fill to full ----------------
        for (int i = 1; i <= DEPTH; i++) begin
            w_en = 1'b1;
            w_data = DATA_W'(i);
            #1;
            chk("fill_mwen", 64'(m_w_en), 64'd1);
            chk("fill_waddr", 64'(m_w_addr), 64'(i - 1));
            chk("fill_wdata", 64'(m_w_data), 64'(i));
            tick();
            chk("fill_level", 64'(level), 64'(i));
        end
        w_en = 1'b0;
        chk("full_flag", 64'(w_full), 64'd1);
        chk("full_notempty", 64'(r_empty), 64'd0);

        // overflow attempt
        w_en = 1'b1;
        w_data = 32'h99;
        #1;
        chk("ovf_no_write", 64'(m_w_en), 64'd0);
        tick();
        w_en = 1'b0;
        chk("ovf_pulse", 64'(w_overflow), 64'd1);
        chk("ovf_level", 64'(level), 64'd16);
        tick();
        chk("ovf_pulse_end", 64'(w_overflow), 64'd0);

        // ---------------- drain from full ----------------
        for (int i = 1; i <= DEPTH; i++) begin
            r_en = 1'b1;
            #1;
            chk("drain_mren", 64'(m_r_en), 64'd1);
            chk("drain_raddr", 64'(m_r_addr), 64'(i - 1));
            tick();
            chk("drain_valid", 64'(r_valid), 64'd1);
            chk("drain_data", 64'(r_data), 64'(i));
        end
        r_en = 1'b0;
        chk("drain_empty", 64'(r_empty), 64'd1);
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_notfull", 64'(w_full), 64'd0);
        tick();
        chk("drain_valid_low", 64'(r_valid), 64'd0);

        // underflow attempt
        r_en = 1'b1;
        #1;
        chk("unf_no_read", 64'(m_r_en), 64'd0);
        tick();
        r_en = 1'b0;
        chk("unf_pulse", 64'(r_underflow), 64'd1);
        chk("unf_valid", 64'(r_valid), 64'd0);
        tick();
        chk("unf_pulse_end", 64'(r_underflow), 64'd0);

        // ---------------- steady push+pop at level 5 ----------------
        for (int i = 0; i < 5; i++) begin
            w_en = 1'b1;
            w_data = 32'h100 + 32'(i);
            exp_q.push_back(w_data);
            tick();
        end
        w_en = 1'b0;
        chk("lvl5", 64'(level), 64'd5);
        for (int k = 0; k < 40; k++) begin
            w_en = 1'b1;
            r_en = 1'b1;
            w_data = 32'h200 + 32'(k);
            exp_word = exp_q.pop_front();
            exp_q.push_back(w_data);
            tick();
            chk("pp_level", 64'(level), 64'd5);
            chk("pp_valid", 64'(r_valid), 64'd1);
            chk("pp_data", 64'(r_data), 64'(exp_word));
        end
        w_en = 1'b0;
        // 16+5+40 pushes and 16+40 pops since reset
        chk("pp_wptr_wrap", 64'(m_w_addr), 64'(61 % 16));
        chk("pp_rptr_wrap", 64'(m_r_addr), 64'(56 % 16));
        for (int i = 0; i < 5; i++) begin
            exp_word = exp_q.pop_front();
            tick();
            chk("pp_tail_data", 64'(r_data), 64'(exp_word));
        end
        r_en = 1'b0;
        chk("pp_tail_empty", 64'(r_empty), 64'd1);

        // ---------------- push+pop on empty / full ----------------
        w_en = 1'b1;
        r_en = 1'b1;
        w_data = 32'h300;
        #1;
        chk("pe_mwen", 64'(m_w_en), 64'd1);
        chk("pe_mren", 64'(m_r_en), 64'd0);
        tick();
        r_en = 1'b0;
        chk("pe_level", 64'(level), 64'd1);
        chk("pe_valid", 64'(r_valid), 64'd0);
        chk("pe_unf", 64'(r_underflow), 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            w_data = 32'h300 + 32'(i);
            tick();
        end
        chk("pf_full", 64'(w_full), 64'd1);
        r_en = 1'b1;
        w_data = 32'h3FF;
        #1;
        chk("pf_mwen", 64'(m_w_en), 64'd0);
        chk("pf_mren", 64'(m_r_en), 64'd1);
        tick();
        w_en = 1'b0;
        r_en = 1'b0;
        chk("pf_level", 64'(level), 64'd15);
        chk("pf_valid", 64'(r_valid), 64'd1);
        chk("pf_data", 64'(r_data), 64'h300);
        chk("pf_notfull", 64'(w_full), 64'd0);
        chk("pf_ovf", 64'(w_overflow), 64'd1);

        // ---------------- async reset mid-burst ----------------
        r_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("ar_level9", 64'(level), 64'd9);
        chk("ar_valid_before", 64'(r_valid), 64'd1);
        #1;
        arst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(r_valid), 64'd0);
        chk("ar_level", 64'(level), 64'd0);
        chk("ar_empty", 64'(r_empty), 64'd1);
        tick();
        r_en = 1'b0;
        arst_n = 1'b1;
        #1;
        chk("ar_hold_level", 64'(level), 64'd0);
        chk("ar_hold_raddr", 64'(m_r_addr), 64'd0);
        w_en = 1'b1;
        w_data = 32'hA5;
        tick();
        w_en = 1'b0;
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk("ar_a5_valid", 64'(r_valid), 64'd1);
        chk("ar_a5_data", 64'(r_data), 64'hA5);

        // ---------------- synchronous clear overrides push ----------------
        w_en = 1'b1;
        w_data = 32'h5A;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w_en = 1'b0;
        chk("sr_level", 64'(level), 64'd0);
        chk("sr_empty", 64'(r_empty), 64'd1);
        chk("sr_waddr", 64'(m_w_addr), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iob_fifo_t2p_ctrl.md
# iob_fifo_t2p_ctrl

Synchronous FIFO controller that drives an external true two-port RAM: one write port and one read port, registered read data with 1-cycle latency. It owns the write/read pointers, occupancy count and full/empty flags, and issues RAM write and read commands. Used by the cache write-through buffer and any block needing a RAM-backed FIFO, with the RAM instantiated alongside in the parent.

## Interface
- ADDR_W, 4: RAM address width; FIFO depth = 2**ADDR_W words.
- DATA_W, 32: word width.
- clk_i  in  1  clock, all logic on rising edge.
- arst_n_i  in  1  asynchronous reset, active-low.
- rst_i  in  1  synchronous clear, active-high; same end state as reset.
- w_en_i  in  1  push request.
- w_data_i  in  DATA_W  push data.
- w_full_o  out  1  FIFO full; push ignored.
- w_overflow_o  out  1  1-cycle pulse: push requested while full.
- r_en_i  in  1  pop request.
- r_data_o  out  DATA_W  popped word; valid when r_valid_o=1.
- r_valid_o  out  1  high the cycle after an accepted pop.
- r_empty_o  out  1  FIFO empty; pop ignored.
- r_underflow_o  out  1  1-cycle pulse: pop requested while empty.
- level_o  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- ext_mem_w_en_o  out  1  RAM write enable.
- ext_mem_w_addr_o  out  ADDR_W  RAM write address.
- ext_mem_w_data_o  out  DATA_W  RAM write data.
- ext_mem_r_en_o  out  1  RAM read enable.
- ext_mem_r_addr_o  out  ADDR_W  RAM read address.
- ext_mem_r_data_i  in  DATA_W  RAM read data (registered in RAM, 1-cycle latency).

## Operation
- Push accepted iff w_en_i=1 and w_full_o=0: ext_mem_w_en_o=1, w_addr=wptr, w_data=w_data_i; wptr increments.
- Pop accepted iff r_en_i=1 and r_empty_o=0: ext_mem_r_en_o=1, r_addr=rptr; rptr increments.
- ext_mem_* command outputs are combinational from request and current flags; ext_mem_w_addr_o=wptr, ext_mem_r_addr_o=rptr at all times.
- r_data_o = ext_mem_r_data_i passthrough; r_valid_o is a register set by an accepted pop.
- Pointers are ADDR_W bits, wrap modulo 2**ADDR_W.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags registered from next level: r_empty_o = (level==0), w_full_o = (level==2**ADDR_W).
- Simultaneous push+pop: each judged against current flags. Empty: push accepted, pop rejected (no fall-through). Full: pop accepted, push rejected. Otherwise both accepted, level unchanged.
- Rejected requests have no state effect except the overflow/underflow pulse.

## Timing
- Reset/clear values: wptr=0, rptr=0, level_o=0, r_empty_o=1, w_full_o=0, r_valid_o=0, w_overflow_o=0, r_underflow_o=0.
- Async reset asserts immediately, deasserts synchronously (parent supplies synchronized release); rst_i acts on the next edge and overrides pushes/pops in that cycle.
- Reset mid-operation discards contents; RAM contents not cleared; a pending r_valid_o is dropped.
- Push at edge N: flags/level update at N; word readable by a pop issued in cycle N+1 or later.
- Pop at edge N: r_valid_o and r_data_o valid in cycle after N (1-cycle latency); back-to-back pops give one word per cycle.
- Overflow/underflow pulses registered, high for exactly the cycle after the offending request.

## Structure
- Constants ADDR_W/DATA_W defaults in iob_fifo_t2p_ctrl_conf.vh, matching iob_ram_t2p conf header.
- One sub-module: iob_fifo_t2p_ptr, ADDR_W-bit wrapping counter with enable and sync clear, instantiated for wptr and rptr.
- RAM not instantiated inside; parent connects ext_mem_* to the two-port RAM.

## Test plan
- Reset, then ADDR_W=4: all outputs at reset values, r_empty_o=1, level_o=0.
- Push 16 words 0x1..0x10 -> w_full_o=1 after 16th edge, level_o=16; 17th push -> no RAM write, w_overflow_o pulses one cycle.
- Pop 16 from full -> r_data_o sequence 0x1..0x10 with r_valid_o one cycle after each pop; then r_empty_o=1; extra pop -> r_underflow_o pulse, ext_mem_r_en_o=0.
- Push+pop same cycle at level 5 for 40 cycles -> level_o stays 5, pointers wrap, data order preserved.
- Push+pop on empty -> push only, level_o=1, r_valid_o=0; push+pop on full -> pop only, level_o=15.
- Assert arst_n_i low mid-burst at level 9 with pop pending -> r_valid_o=0 next cycle, level_o=0, r_empty_o=1; subsequent push 0xA5/pop returns 0xA5.
